// File: rtl/ddr_frame_pkg.sv
// Shared definitions for the DDR frame engines: write-engine state encoding
// and the position of the two-bit bank field at the top of a DDR word address.
package ddr_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_REQ   = 3'd2,
    ST_DATA  = 3'd3,
    ST_DONE  = 3'd4
  } wr_state_t;

  // Bank select occupies the top BANK_W bits of every DDR word address.
  localparam int BANK_W = 2;

  // Lowest bit index of the bank field for a given address width.
  function automatic int bank_lsb(input int addr_w);
    return addr_w - BANK_W;
  endfunction

endpackage

// File: rtl/ddr_burst_addr_gen.sv
// Burst index counter and burst start-address formation for one frame.
// The in-bank offset wraps modulo the bank size and never touches the bank bits.
module ddr_burst_addr_gen
  import ddr_frame_pkg::*;
#(
  parameter int ADDR_W       = 25,
  parameter int BURST_LEN    = 64,
  parameter int FRAME_BURSTS = 4800,
  parameter int BASE_ADDR    = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              restart_i,  // new frame: latch bank, index back to 0
  input  logic [BANK_W-1:0] bank_i,
  input  logic              advance_i,  // step to the next burst of the frame
  input  logic              addr_en_i,  // refresh the registered start address
  output logic              last_o,     // current burst is the final one
  output logic [ADDR_W-1:0] addr_o
);

  localparam int OFF_W = bank_lsb(ADDR_W);
  localparam int IDX_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;

  logic [BANK_W-1:0] bank_q, bank_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q;
  logic [OFF_W-1:0]  offset;

  // Offset arithmetic is done at OFF_W bits so overflow simply wraps in-bank.
  assign offset = OFF_W'(BASE_ADDR) + OFF_W'(idx_q) * OFF_W'(BURST_LEN);
  assign last_o = (idx_q == IDX_W'(FRAME_BURSTS - 1));
  assign addr_o = addr_q;

  // Next bank / burst index: restart wins over advance.
  always_comb begin
    bank_d = bank_q;
    idx_d  = idx_q;
    if (restart_i) begin
      bank_d = bank_i;
      idx_d  = '0;
    end else if (advance_i) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Bank, index and the registered burst start address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_q <= '0;
      idx_q  <= '0;
      addr_q <= '0;
    end else begin
      bank_q <= bank_d;
      idx_q  <= idx_d;
      if (addr_en_i) addr_q <= {bank_q, offset};
    end
  end

endmodule

// File: rtl/ddr_frame_writer.sv
// Per-channel DDR frame write engine: drains a show-ahead FIFO into one bank
// as fixed-length bursts and pulses frame_wr_done after the last beat.
// Optional macro FRAME_WR_ERR_EN adds a sticky frame_err truncation flag.
module ddr_frame_writer
  import ddr_frame_pkg::*;
#(
  parameter int ADDR_W       = 25,
  parameter int DATA_W       = 64,
  parameter int BURST_LEN    = 64,
  parameter int FRAME_BURSTS = 4800,
  parameter int BASE_ADDR    = 0
) (
  input  logic                           ddr_clk,
  input  logic                           sys_rstn,
  input  logic                           wr_load,
  input  logic [BANK_W-1:0]              wr_bank,
  input  logic [$clog2(BURST_LEN)+1:0]   fifo_rd_cnt,
  input  logic [DATA_W-1:0]              fifo_rd_data,
  output logic                           fifo_rd_en,
  output logic                           wr_req,
  input  logic                           wr_grant,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic [DATA_W-1:0]              wr_data,
  input  logic                           wr_data_rdy,
  output logic                           frame_wr_done,
  output logic                           busy
`ifdef FRAME_WR_ERR_EN
  ,
  output logic                           frame_err
`endif
);

  localparam int CNT_W  = $clog2(BURST_LEN) + 2;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  wr_state_t         state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              pend_q, pend_d;
  logic [BANK_W-1:0] pend_bank_q, pend_bank_d;
  logic              restart, advance, last_burst, burst_end;
  logic [BANK_W-1:0] restart_bank;

  assign burst_end = (state_q == ST_DATA) && wr_data_rdy &&
                     (beat_q == BEAT_W'(BURST_LEN - 1));

  ddr_burst_addr_gen #(
    .ADDR_W      (ADDR_W),
    .BURST_LEN   (BURST_LEN),
    .FRAME_BURSTS(FRAME_BURSTS),
    .BASE_ADDR   (BASE_ADDR)
  ) u_addr_gen (
    .clk_i    (ddr_clk),
    .rst_ni   (sys_rstn),
    .restart_i(restart),
    .bank_i   (restart_bank),
    .advance_i(advance),
    .addr_en_i(state_q == ST_ARMED),
    .last_o   (last_burst),
    .addr_o   (wr_addr)
  );

  // Next-state logic; a load during a burst is parked so the burst always finishes.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    pend_d       = pend_q;
    pend_bank_d  = pend_bank_q;
    restart      = 1'b0;
    restart_bank = wr_bank;
    advance      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_load) begin
          restart = 1'b1;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // A fresh load restarts the frame; the threshold is re-evaluated next cycle.
        if (wr_load) begin
          restart = 1'b1;
        end else if (fifo_rd_cnt >= CNT_W'(BURST_LEN)) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (wr_load) begin
          pend_d      = 1'b1;
          pend_bank_d = wr_bank;
        end
        if (wr_grant) begin
          beat_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (wr_data_rdy) beat_d = beat_q + 1'b1;
        if (burst_end) begin
          if (pend_q || (wr_load && !last_burst)) begin
            // Truncated frame: restart with the newest requested bank.
            restart      = 1'b1;
            restart_bank = wr_load ? wr_bank : pend_bank_q;
            pend_d       = 1'b0;
            state_d      = ST_ARMED;
          end else if (last_burst) begin
            // A load on the final beat does not truncate; it arms after DONE.
            if (wr_load) begin
              pend_d      = 1'b1;
              pend_bank_d = wr_bank;
            end
            state_d = ST_DONE;
          end else begin
            advance = 1'b1;
            state_d = ST_ARMED;
          end
        end else if (wr_load) begin
          pend_d      = 1'b1;
          pend_bank_d = wr_bank;
        end
      end
      ST_DONE: begin
        if (wr_load || pend_q) begin
          restart      = 1'b1;
          restart_bank = wr_load ? wr_bank : pend_bank_q;
          pend_d       = 1'b0;
          state_d      = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, beat counter and parked-load registers.
  always_ff @(posedge ddr_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      pend_q      <= 1'b0;
      pend_bank_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      pend_q      <= pend_d;
      pend_bank_q <= pend_bank_d;
    end
  end

  assign wr_req        = (state_q == ST_REQ);
  assign fifo_rd_en    = (state_q == ST_DATA) && wr_data_rdy;
  assign wr_data       = (state_q == ST_DATA) ? fifo_rd_data : '0;
  assign frame_wr_done = (state_q == ST_DONE);
  assign busy          = (state_q != ST_IDLE);

`ifdef FRAME_WR_ERR_EN
  logic err_q, truncate;

  // Any load that cuts short an active frame; a load on the final beat does not.
  assign truncate = wr_load &&
                    ((state_q == ST_ARMED) || (state_q == ST_REQ) ||
                     ((state_q == ST_DATA) && !(burst_end && last_burst && !pend_q)));

  // Sticky truncation flag, cleared by the next completed frame.
  always_ff @(posedge ddr_clk or negedge sys_rstn) begin
    if (!sys_rstn)                err_q <= 1'b0;
    else if (truncate)            err_q <= 1'b1;
    else if (state_q == ST_DONE)  err_q <= 1'b0;
  end

  assign frame_err = err_q;
`endif

endmodule

// File: tb/tb_ddr_frame_writer.sv
// Self-checking bench for ddr_frame_writer: directed test-plan scenarios plus
// a randomized run, both checked cycle by cycle against a transaction model.
module tb_ddr_frame_writer;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 64;
  localparam int BL     = 4;
  localparam int FB     = 3;
  localparam int BASE0  = 'h10;
  localparam int BASE1  = 'h7FFFFC;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              ld = 1'b0;
  logic [1:0]        bk = 2'b00;
  logic [3:0]        cnt = 4'd0;
  logic [DATA_W-1:0] rdata = '0;
  logic              gnt = 1'b0;
  logic              rdy = 1'b0;

  logic              en0, req0, done0, busy0, en1, req1, done1, busy1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
`ifdef FRAME_WR_ERR_EN
  logic              err0, err1;
`endif

  always #5 clk = ~clk;

  ddr_frame_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL),
                     .FRAME_BURSTS(FB), .BASE_ADDR(BASE0)) u_dut (
    .ddr_clk(clk), .sys_rstn(rstn), .wr_load(ld), .wr_bank(bk),
    .fifo_rd_cnt(cnt), .fifo_rd_data(rdata), .fifo_rd_en(en0),
    .wr_req(req0), .wr_grant(gnt), .wr_addr(addr0), .wr_data(data0),
    .wr_data_rdy(rdy), .frame_wr_done(done0), .busy(busy0)
`ifdef FRAME_WR_ERR_EN
    , .frame_err(err0)
`endif
  );

  // Same stimulus, base near the top of the bank to exercise offset wrap.
  ddr_frame_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL),
                     .FRAME_BURSTS(FB), .BASE_ADDR(BASE1)) u_wrap (
    .ddr_clk(clk), .sys_rstn(rstn), .wr_load(ld), .wr_bank(bk),
    .fifo_rd_cnt(cnt), .fifo_rd_data(rdata), .fifo_rd_en(en1),
    .wr_req(req1), .wr_grant(gnt), .wr_addr(addr1), .wr_data(data1),
    .wr_data_rdy(rdy), .frame_wr_done(done1), .busy(busy1)
`ifdef FRAME_WR_ERR_EN
    , .frame_err(err1)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (frame / burst bookkeeping) ----------------
  bit          m_active, m_req, m_burst, m_done, m_pend, m_err;
  int          m_beats, m_idx, m_bank, m_pbank;
  logic [24:0] m_addr0, m_addr1;

  function automatic logic [24:0] addr_of(input int base, input int bank, input int idx);
    int off;
    off = (base + idx * BL) % (1 << 23);
    return 25'(bank * (1 << 23) + off);
  endfunction

  task automatic model_reset();
    m_active = 0; m_req = 0; m_burst = 0; m_done = 0; m_pend = 0; m_err = 0;
    m_beats = 0; m_idx = 0; m_bank = 0; m_pbank = 0;
    m_addr0 = '0; m_addr1 = '0;
  endtask

  task automatic arm(input int b);
    m_active = 1; m_req = 0; m_burst = 0; m_bank = b; m_idx = 0;
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    bit last_beat, last_frame;
    if (m_done) begin
      m_done = 0;
      m_err  = 0;
      if (m_pend || ld) begin
        arm(ld ? int'(bk) : m_pbank);
        m_pend = 0;
      end
    end else if (!m_active) begin
      if (ld) arm(int'(bk));
    end else if (!m_req && !m_burst) begin
      m_addr0 = addr_of(BASE0, m_bank, m_idx);
      m_addr1 = addr_of(BASE1, m_bank, m_idx);
      if (ld) begin
        arm(int'(bk));
        m_err = 1;
      end else if (int'(cnt) >= BL) begin
        m_req = 1;
      end
    end else if (m_req) begin
      if (ld) begin m_pend = 1; m_pbank = int'(bk); m_err = 1; end
      if (gnt) begin m_req = 0; m_burst = 1; m_beats = 0; end
    end else begin
      last_beat  = rdy && (m_beats == BL - 1);
      last_frame = (m_idx == FB - 1);
      if (rdy) m_beats++;
      if (last_beat) begin
        m_burst = 0;
        if (m_pend || (ld && !last_frame)) begin
          if (ld) m_err = 1;
          arm(ld ? int'(bk) : m_pbank);
          m_pend = 0;
        end else if (last_frame) begin
          if (ld) begin m_pend = 1; m_pbank = int'(bk); end
          m_active = 0;
          m_done   = 1;
        end else begin
          m_idx++;
        end
      end else if (ld) begin
        m_pend = 1; m_pbank = int'(bk); m_err = 1;
      end
    end
  endtask

  // ---------------- observation / per-cycle comparison ----------------
  logic [24:0] q0[$];
  logic [24:0] q1[$];
  int pops, dones, cyc, last_pop_cyc, done_cyc;
  int rdy_mode;  // 0: always ready, 1: alternate, 2: random

  task automatic compare_all();
    check_val("wr_req",     64'(req0),  64'(m_req));
    check_val("busy",       64'(busy0), 64'(m_active | m_done));
    check_val("frame_done", 64'(done0), 64'(m_done));
    check_val("fifo_rd_en", 64'(en0),   64'(m_burst & rdy));
    check_val("wr_data",    data0,      m_burst ? rdata : 64'd0);
    check_val("wr_addr",    64'(addr0), 64'(m_addr0));
    check_val("wr_addr_wrap", 64'(addr1), 64'(m_addr1));
    check_val("busy_wrap",  64'(busy1), 64'(m_active | m_done));
`ifdef FRAME_WR_ERR_EN
    check_val("frame_err",  64'(err0),  64'(m_err));
`endif
  endtask

  task automatic cycle();
    #1;
    if (req0 && gnt) begin
      q0.push_back(addr0);
      q1.push_back(addr1);
      $display("[%0d] burst granted: addr=0x%07h wrap_addr=0x%07h", cyc, addr0, addr1);
    end
    if (en0) begin pops++; last_pop_cyc = cyc; end
    if (done0) begin
      dones++; done_cyc = cyc;
      $display("[%0d] frame done (bank %0d, truncated-before=%0d)", cyc, m_bank, m_err);
    end
    compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic step();
    gnt   = m_req;
    rdata = {$urandom, $urandom};
    case (rdy_mode)
      0: rdy = 1'b1;
      1: rdy = cyc[0];
      default: rdy = ($urandom_range(0, 3) != 0);
    endcase
    cycle();
  endtask

  task automatic clear_counts();
    pops = 0; dones = 0; q0.delete(); q1.delete();
  endtask

  task automatic run_until_done(input int max);
    int n = 0;
    int d0 = dones;
    while (dones == d0 && n < max) begin step(); n++; end
    check_val("done_within_budget", 64'(dones != d0), 64'd1);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_req"},  64'(req0),  64'd0);
    check_val({tag, "_busy"}, 64'(busy0), 64'd0);
    check_val({tag, "_en"},   64'(en0),   64'd0);
    check_val({tag, "_done"}, 64'(done0), 64'd0);
    check_val({tag, "_addr"}, 64'(addr0), 64'd0);
    check_val({tag, "_data"}, data0,      64'd0);
  endtask

  initial begin
    int n;
    cyc = 0; rdy_mode = 0;
    model_reset();
    clear_counts();

    // Reset: all outputs 0.
    #2 rstn = 1'b0;
    rdata = 64'hDEAD_BEEF_0123_4567;
    @(negedge clk); @(negedge clk);
    check_zero("reset");
    rstn = 1'b1;
    repeat (3) step();

    // Full frame, FIFO full, always ready: 3 bursts, 12 pops, one done.
    clear_counts();
    cnt = 4'd15; ld = 1'b1; bk = 2'd1;
    step();
    ld = 1'b0;
    run_until_done(100);
    repeat (3) step();
    check_val("pops_frame", 64'(pops), 64'd12);
    check_val("dones_frame", 64'(dones), 64'd1);
    check_val("done_latency", 64'(done_cyc - last_pop_cyc), 64'd1);
    check_val("bursts_frame", 64'(q0.size()), 64'd3);
    if (q0.size() == 3 && q1.size() == 3) begin
      check_val("addr_b0", 64'(q0[0]), 64'h0800010);
      check_val("addr_b1", 64'(q0[1]), 64'h0800014);
      check_val("addr_b2", 64'(q0[2]), 64'h0800018);
      check_val("wrap_b0", 64'(q1[0]), 64'h0FFFFFC);
      check_val("wrap_b1", 64'(q1[1]), 64'h0800000);
    end

    // FIFO threshold: 3 words never request, 4 requests on the next cycle.
    clear_counts();
    cnt = 4'd3; ld = 1'b1; bk = 2'd0;
    step();
    ld = 1'b0;
    repeat (5) step();
    check_val("req_below_thr", 64'(req0), 64'd0);
    cnt = 4'd4;
    step();
    check_val("req_at_thr", 64'(req0), 64'd1);

    // Ready alternating: the frame still moves exactly 12 beats.
    rdy_mode = 1;
    cnt = 4'd15;
    run_until_done(200);
    repeat (2) step();
    check_val("pops_toggle", 64'(pops), 64'd12);
    check_val("dones_toggle", 64'(dones), 64'd1);
    rdy_mode = 0;

    // Load to bank 3 on the 2nd beat of burst 1: burst completes, restart, no done.
    clear_counts();
    ld = 1'b1; bk = 2'd1;
    step();
    ld = 1'b0;
    n = 0;
    while (!(m_burst && m_idx == 1 && m_beats == 1) && n < 100) begin step(); n++; end
    check_val("reach_burst1", 64'(n < 100), 64'd1);
    ld = 1'b1; bk = 2'd3;
    step();
    ld = 1'b0;
    n = 0;
    while (q0.size() < 3 && n < 100) begin step(); n++; end
    check_val("restart_grants", 64'(q0.size()), 64'd3);
    if (q0.size() == 3) check_val("restart_addr", 64'(q0[2]), 64'h1800010);
    check_val("no_done_trunc", 64'(dones), 64'd0);
`ifdef FRAME_WR_ERR_EN
    check_val("frame_err_set", 64'(err0), 64'd1);
`endif
    run_until_done(100);
    repeat (2) step();

    // Asynchronous reset in the middle of a burst.
    ld = 1'b1; bk = 2'd2;
    step();
    ld = 1'b0;
    n = 0;
    while (!(m_burst && m_beats == 2) && n < 100) begin step(); n++; end
    check_val("reach_data", 64'(n < 100), 64'd1);
    #2 rstn = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    repeat (5) step();
    check_val("idle_after_rst", 64'(busy0), 64'd0);

    // Randomized traffic against the model.
    rdy_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      ld  = ($urandom_range(0, 59) == 0);
      bk  = 2'($urandom_range(0, 3));
      cnt = 4'($urandom_range(0, 15));
      gnt = m_req && ($urandom_range(0, 2) == 0);
      rdata = {$urandom, $urandom};
      rdy = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr_frame_writer.md
# ddr_frame_writer

Per-channel DDR write engine that consumes the `wr_bank` / `wr_load` pair produced by the bank-switch controller. It drains one channel's show-ahead pixel FIFO into DDR as fixed-length bursts inside the selected bank. When the whole frame has been written, it returns a one-cycle `frame_wr_done` to the controller. Nine instances sit between the camera-side write FIFOs and the DDR port arbiter, one per slave.

## Interface
Parameters:
- ADDR_W, 25, DDR word address width; bank field is bits [ADDR_W-1:ADDR_W-2]
- DATA_W, 64, FIFO/DDR data width
- BURST_LEN, 64, beats per DDR burst (power of two)
- FRAME_BURSTS, 4800, bursts per frame
- BASE_ADDR, 0, channel region offset inside a bank (ADDR_W-2 bits)

Ports (one clock; reset is asynchronous and active-low):
- ddr_clk  in  1  sole clock
- sys_rstn  in  1  asynchronous active-low reset
- wr_load  in  1  pulse: arm a new frame
- wr_bank  in  2  bank for the frame; sampled when wr_load is high
- fifo_rd_cnt  in  clog2(BURST_LEN)+2  words available in the FIFO
- fifo_rd_data  in  DATA_W  show-ahead FIFO head
- fifo_rd_en  out  1  FIFO pop
- wr_req  out  1  burst request to the arbiter
- wr_grant  in  1  arbiter accept; one-cycle pulse
- wr_addr  out  ADDR_W  burst start address
- wr_data  out  DATA_W  write beat
- wr_data_rdy  in  1  DDR accepts a beat this cycle
- frame_wr_done  out  1  one-cycle pulse after the last beat of the frame
- busy  out  1  state is not IDLE

## Operation
States and transitions:
- IDLE: wait for wr_load.
  - On wr_load: latch bank, set burst_idx=0, go to ARMED.
- ARMED: frame is active, waiting for data.
  - When fifo_rd_cnt >= BURST_LEN, go to REQ.
- REQ: wr_req=1, wr_addr held stable.
  - On wr_grant, clear beat_cnt and go to DATA.
- DATA: wr_data = fifo_rd_data (combinational); fifo_rd_en = wr_data_rdy.
  - beat_cnt increments on each wr_data_rdy.
  - On the beat with beat_cnt = BURST_LEN-1:
    - If burst_idx = FRAME_BURSTS-1, go to DONE.
    - Otherwise increment burst_idx and go to ARMED.
- DONE: frame_wr_done=1 for exactly one cycle, then go to IDLE.

Address rule:
- wr_addr = {bank, (BASE_ADDR + burst_idx*BURST_LEN) mod 2^(ADDR_W-2)}.
- The offset wraps inside the bank and never carries into the bank bits.

wr_load mid-frame:
- In ARMED: restart immediately with the new bank and burst_idx=0. No frame_wr_done is produced.
- In REQ or DATA: the current burst always completes, so the DDR protocol is never broken. The load (and its bank) is held in a pending flag. After the burst ends, the block restarts in ARMED with the pending bank and burst_idx=0; no frame_wr_done.
- In DONE: the pending load is honoured on the next cycle.

Other boundary rules:
- wr_load in the same cycle as the final beat: DONE still pulses, then the pending load arms.
- fifo_rd_cnt never underflows: a burst starts only once BURST_LEN words are present.

## Timing
Reset values:
- All outputs 0; wr_addr = 0; state IDLE; pending flag cleared.
- Reset mid-burst abandons the burst immediately.

Latencies:
- wr_load at cycle N → busy=1 at N+1.
- fifo_rd_cnt threshold seen at cycle M → wr_req=1 at M+1.
- wr_grant at cycle G → first possible beat at G+1.
- Last beat at cycle L → frame_wr_done at L+1.

Handshake and register rules:
- wr_req drops the cycle after wr_grant.
- wr_addr is registered and changes only in ARMED.
- beat_cnt is clog2(BURST_LEN) bits; burst_idx is clog2(FRAME_BURSTS) bits.

## Configuration
- FRAME_WR_ERR_EN defined:
  - Adds output frame_err (1 bit, reset 0).
  - Set sticky on any wr_load that truncates an active frame.
  - Cleared on the next clean frame_wr_done.
- FRAME_WR_ERR_EN undefined:
  - No port, no logic; truncation is silent.

## Structure
- Shared package `ddr_frame_pkg` holds:
  - the state enum;
  - the bank-field position constants (shared with the read engine and the bank-switch controller).
- One natural sub-module: `ddr_burst_addr_gen`, covering the burst_idx counter and address formation.
- The FSM and beat counter live in the top.

## Test plan
- BURST_LEN=4, FRAME_BURSTS=3, BASE_ADDR=0x10, wr_bank=2'b01, FIFO always full, wr_data_rdy=1 → expect:
  - wr_addr 0x0800010, 0x0800014, 0x0800018;
  - 12 pops;
  - frame_wr_done exactly once, 1 cycle after the 12th beat.
- fifo_rd_cnt held at 3 (BURST_LEN=4) → wr_req stays 0; raise it to 4 → wr_req=1 on the next cycle.
- wr_data_rdy toggling 1/0 during DATA → pops equal the number of rdy cycles; the burst ends after exactly 4 accepted beats.
- wr_load with wr_bank=3 during the 2nd beat of burst 1 → expect:
  - the burst completes;
  - the next wr_addr is {2'b11, BASE_ADDR};
  - no frame_wr_done;
  - frame_err=1 when FRAME_WR_ERR_EN is defined.
- BASE_ADDR=0x7FFFFC, BURST_LEN=4 → second burst address offset wraps to 0x000000 with bank bits unchanged.
- sys_rstn low during DATA → all outputs are 0 asynchronously; after release, the block waits in IDLE for wr_load.
